// File: rtl/mem_access_trace_buffer.sv
// Multi-channel memory-access trace recorder: per-channel hold registers, round-robin
// arbitration into a timestamped circular buffer drained through a valid/ready port.
module mem_access_trace_buffer #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned OCC_W = PTR_W + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     mode_wrap_i,
    input  logic                     clear_i,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [CH_W-1:0]          rd_ch_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    output logic [TS_W-1:0]          rd_time_o,
    output logic [OCC_W-1:0]         count_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    logic [TS_W-1:0]   ts_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] haddr_q [NUM_CH];
    logic [TS_W-1:0]   hts_q   [NUM_CH];
    logic [CH_W-1:0]   rr_q;

    logic [CH_W-1:0]   mem_ch   [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  count_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              full, pop, push, overwrite, gnt_valid;
    logic [CH_W-1:0]   gnt_idx, cand;
    logic [NUM_CH-1:0] gnt_vec, accept, drop;
    logic [CNT_W+3:0]  drop_sum;

    assign full      = (count_q == OCC_W'(DEPTH));
    assign pop       = (count_q != '0) && rd_ready_i;
    assign push      = gnt_valid;
    assign overwrite = push && full && !pop;

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((32'(rr_q) + i) % NUM_CH);
            if (!gnt_valid && pend_q[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_valid = gnt_valid && (!full || mode_wrap_i || pop);
        gnt_vec   = '0;
        if (gnt_valid) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // A hold being drained this cycle can take a new event at the same edge.
    always_comb begin
        accept   = {NUM_CH{en_i}} & ch_valid_i & (~pend_q | gnt_vec);
        drop     = {NUM_CH{en_i}} & ch_valid_i & ~accept;
        pend_d   = accept | (pend_q & ~gnt_vec);
        drop_sum = (CNT_W+4)'(drop_q) + (CNT_W+4)'($countones(drop));
        if (drop_sum > {4'b0000, {CNT_W{1'b1}}}) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            pend_q     <= '0;
            rr_q       <= CH_W'(NUM_CH - 1);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (clear_i) begin
                pend_q     <= '0;
                rr_q       <= CH_W'(NUM_CH - 1);
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end else begin
                pend_q <= pend_d;
                drop_q <= drop_d;
                if (push) begin
                    rr_q     <= gnt_idx;
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                // Overwrite in wrap mode evicts the oldest entry.
                if (pop || overwrite) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (push && !pop && !full) begin
                    count_q <= count_q + OCC_W'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - OCC_W'(1);
                end
                if (overwrite || (drop != '0)) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (accept[k]) begin
                haddr_q[k] <= ch_addr_i[k*ADDR_W +: ADDR_W];
                hts_q[k]   <= ts_q;
            end
        end
        if (push && !rst_i && !clear_i) begin
            mem_ch[wr_ptr_q]   <= gnt_idx;
            mem_addr[wr_ptr_q] <= haddr_q[gnt_idx];
            mem_ts[wr_ptr_q]   <= hts_q[gnt_idx];
        end
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_ch_o    = mem_ch[rd_ptr_q];
    assign rd_addr_o  = mem_addr[rd_ptr_q];
    assign rd_time_o  = mem_ts[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_mem_access_trace_buffer.sv
// Bench for mem_access_trace_buffer: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_mem_access_trace_buffer;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CNT_W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, wrap = 1'b0, clr = 1'b0, rdy = 1'b0;
    logic [1:0]  chv = '0;
    logic [63:0] chaddr = '0;
    logic        rd_valid;
    logic [0:0]  rd_ch;
    logic [31:0] rd_addr;
    logic [15:0] rd_time;
    logic [4:0]  count;
    logic        ovf;
    logic [15:0] drop;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_trace_buffer #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .mode_wrap_i (wrap),
        .clear_i     (clr),
        .ch_valid_i  (chv),
        .ch_addr_i   (chaddr),
        .rd_valid_o  (rd_valid),
        .rd_ready_i  (rdy),
        .rd_ch_o     (rd_ch),
        .rd_addr_o   (rd_addr),
        .rd_time_o   (rd_time),
        .count_o     (count),
        .overflow_o  (ovf),
        .drop_cnt_o  (drop)
    );

    // Reference model: a plain queue of recorded events plus per-channel holds.
    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [15:0] ts;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend [NUM_CH];
    logic [31:0] m_haddr [NUM_CH];
    logic [15:0] m_hts [NUM_CH];
    int          m_last;
    bit          m_ovf;
    int          m_drop;
    logic [15:0] m_ts;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(bit r, bit e, bit w, bit c, logic [1:0] v,
                                       logic [31:0] a0, logic [31:0] a1, bit rd);
        bit pop;
        int gnt;
        ent_t n;
        if (r) begin
            mq.delete();
            foreach (m_pend[k]) m_pend[k] = 0;
            m_last = NUM_CH - 1;
            m_ovf  = 0;
            m_drop = 0;
            m_ts   = '0;
            return;
        end
        pop = (mq.size() > 0) && rd;
        gnt = -1;
        for (int i = 1; i <= NUM_CH; i++) begin
            int cc;
            cc = (m_last + i) % NUM_CH;
            if (gnt < 0 && m_pend[cc]) gnt = cc;
        end
        if (gnt >= 0 && !(mq.size() < DEPTH || w || pop)) gnt = -1;
        if (c) begin
            mq.delete();
            foreach (m_pend[k]) m_pend[k] = 0;
            m_last = NUM_CH - 1;
            m_ovf  = 0;
            m_drop = 0;
            m_ts   = m_ts + 16'd1;
            return;
        end
        if (pop) void'(mq.pop_front());
        if (gnt >= 0) begin
            n.ch   = gnt;
            n.addr = m_haddr[gnt];
            n.ts   = m_hts[gnt];
            mq.push_back(n);
            m_last = gnt;
            m_pend[gnt] = 0;
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                m_ovf = 1;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (e && v[k]) begin
                if (!m_pend[k]) begin
                    m_pend[k]  = 1;
                    m_haddr[k] = (k == 0) ? a0 : a1;
                    m_hts[k]   = m_ts;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        m_ts = m_ts + 16'd1;
    endfunction

    task automatic check_model();
        chk("m_count", count, mq.size());
        chk("m_valid", rd_valid, mq.size() > 0);
        chk("m_overflow", ovf, m_ovf);
        chk("m_drop", drop, m_drop);
        if (mq.size() > 0) begin
            chk("m_head_ch", rd_ch, mq[0].ch);
            chk("m_head_addr", rd_addr, mq[0].addr);
            chk("m_head_time", rd_time, mq[0].ts);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input bit r, input bit e, input bit w, input bit c, input logic [1:0] v,
                        input logic [31:0] a0, input logic [31:0] a1, input bit rd);
        rst = r; en = e; wrap = w; clr = c; chv = v; chaddr = {a1, a0}; rdy = rd;
        model_step(r, e, w, c, v, a0, a1, rd);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic fill_full(input bit w);
        for (int i = 0; i < DEPTH; i++) step(0, 1, w, 0, 2'b01, 32'(i), 32'h0, 0);
        step(0, 1, w, 0, 2'b00, 32'h0, 32'h0, 0);
    endtask

    typedef struct {
        bit          rd;
        logic [1:0]  v;
        logic [31:0] a0;
        logic [31:0] a1;
        int          exp_cnt;
        bit          chk_head;
        int          exp_ch;
        logic [31:0] exp_addr;
        logic [15:0] exp_ts;
    } vec_t;

    function automatic vec_t mk(bit rd, logic [1:0] v, logic [31:0] a0, logic [31:0] a1,
                                int cnt, bit hd, int ch, logic [31:0] ad, logic [15:0] ts);
        vec_t t;
        t.rd = rd; t.v = v; t.a0 = a0; t.a1 = a1; t.exp_cnt = cnt;
        t.chk_head = hd; t.exp_ch = ch; t.exp_addr = ad; t.exp_ts = ts;
        return t;
    endfunction

    vec_t tbl [13];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) tbl[i] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 2'b10, 32'h0, 32'h40, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 2'b00, 0, 0, 1, 1, 1, 32'h40, 16'd5);
        tbl[7]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 2'b11, 32'h100, 32'h200, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 2'b00, 0, 0, 1, 1, 0, 32'h100, 16'd8);
        tbl[10] = mk(0, 2'b00, 0, 0, 2, 1, 0, 32'h100, 16'd8);
        tbl[11] = mk(1, 2'b00, 0, 0, 1, 1, 1, 32'h200, 16'd8);
        tbl[12] = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0);
        chk("reset_count", count, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_overflow", ovf, 0);
        chk("reset_drop", drop, 0);

        // Single event at ts=5, then simultaneous ch0/ch1 events at ts=8.
        for (int i = 0; i < 13; i++) begin
            step(0, 1, 0, 0, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].rd);
            chk("vec_count", count, tbl[i].exp_cnt);
            chk("vec_valid", rd_valid, tbl[i].exp_cnt != 0);
            if (tbl[i].chk_head) begin
                chk("vec_ch", rd_ch, tbl[i].exp_ch);
                chk("vec_addr", rd_addr, tbl[i].exp_addr);
                chk("vec_time", rd_time, tbl[i].exp_ts);
            end
        end

        // Full buffer, one pending event, simultaneous pop: no overwrite, no loss.
        step(1, 0, 0, 0, 2'b00, 0, 0, 0);
        fill_full(0);
        chk("full_count", count, 16);
        step(0, 1, 0, 0, 2'b01, 32'hAA, 0, 0);
        chk("full_hold_drop", drop, 0);
        step(0, 1, 0, 0, 2'b00, 0, 0, 1);
        chk("pushpop_count", count, 16);
        chk("pushpop_overflow", ovf, 0);
        chk("pushpop_head", rd_addr, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 2'b00, 0, 0, 1);
        chk("drain_count", count, 0);

        // Hold collision while full in stop mode.
        step(1, 0, 0, 0, 2'b00, 0, 0, 0);
        fill_full(0);
        for (int j = 0; j < 3; j++) step(0, 1, 0, 0, 2'b01, 32'hB0 + 32'(j), 0, 0);
        chk("collide_drop", drop, 2);
        chk("collide_overflow", ovf, 1);
        chk("collide_count", count, 16);

        // Wrap mode: 20 events into 16 entries.
        step(1, 0, 0, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 2'b01, 32'(i), 0, 0);
        step(0, 1, 1, 0, 2'b00, 0, 0, 0);
        chk("wrap_count", count, 16);
        chk("wrap_head", rd_addr, 4);
        chk("wrap_overflow", ovf, 1);
        chk("wrap_drop", drop, 0);

        // Clear mid-run with a strobe in the same cycle, then reset mid-run.
        step(1, 0, 0, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 2'b01, 32'h10 + 32'(i), 0, 0);
        step(0, 1, 0, 0, 2'b00, 0, 0, 0);
        chk("preclear_count", count, 5);
        step(0, 1, 0, 1, 2'b01, 32'hCC, 0, 0);
        chk("clear_count", count, 0);
        chk("clear_drop", drop, 0);
        chk("clear_valid", rd_valid, 0);
        step(0, 1, 0, 0, 2'b01, 32'hDD, 0, 0);
        step(0, 1, 0, 0, 2'b00, 0, 0, 0);
        chk("clear_ts_runs", rd_time, 7);
        chk("clear_discard", rd_addr, 32'hDD);
        step(1, 1, 0, 0, 2'b01, 32'hEE, 0, 0);
        chk("rst_count", count, 0);
        step(0, 1, 0, 0, 2'b01, 32'hEF, 0, 0);
        step(0, 1, 0, 0, 2'b00, 0, 0, 0);
        chk("rst_ts_zero", rd_time, 0);
        chk("rst_addr", rd_addr, 32'hEF);

        // Randomized traffic in blocks with varying wrap mode and read pressure.
        step(1, 0, 0, 0, 2'b00, 0, 0, 0);
        for (int b = 0; b < 10; b++) begin
            bit w;
            int rp;
            w  = $urandom_range(0, 1) == 1;
            rp = $urandom_range(0, 100);
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, w,
                     $urandom_range(0, 149) == 0, 2'($urandom), $urandom, $urandom,
                     $urandom_range(0, 99) < rp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_trace_buffer.md
Name: mem_access_trace_buffer

Overview:
Synthesizable multi-channel memory-access trace recorder. It captures address events from NUM_CH sources (channel 0 = instruction fetch, channel 1 = data memory, more are optional), timestamps them and stores them in a circular buffer. A valid/ready port drains the buffer, so traces can be read on-chip or by a bench instead of by file dumps. It sits beside the CPU and taps IM/DM request signals non-intrusively.

Parameters:
NUM_CH, 2, number of event channels (1..8); CH_W = max(1, clog2(NUM_CH)) derived
ADDR_W, 32, captured address width
DEPTH, 16, buffer entries; power of two, >=2
TS_W, 16, timestamp width
CNT_W, 16, drop counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
en_i  in  1  capture enable
mode_wrap_i  in  1  0 = stop-when-full, 1 = overwrite-oldest
clear_i  in  1  synchronous flush (timestamp unaffected)
ch_valid_i  in  NUM_CH  per-channel event strobe
ch_addr_i  in  NUM_CH*ADDR_W  channel k address in bits [k*ADDR_W +: ADDR_W]
rd_valid_o  out  1  head entry available
rd_ready_i  in  1  consumer accepts head
rd_ch_o  out  CH_W  head channel id
rd_addr_o  out  ADDR_W  head address
rd_time_o  out  TS_W  head timestamp
count_o  out  clog2(DEPTH)+1  occupancy
overflow_o  out  1  sticky loss flag
drop_cnt_o  out  CNT_W  dropped events, saturating

Behaviour:
- Reset (rst_i=1 at edge): timestamp=0, buffer empty, all hold registers empty, RR pointer=NUM_CH-1, count_o=0, rd_valid_o=0, overflow_o=0, drop_cnt_o=0. rst_i has priority over clear_i and all other inputs.
- Timestamp: free-running, increments every non-reset cycle, wraps at 2^TS_W. An event is stamped with the timestamp value in the cycle its strobe is sampled.
- Per-channel hold register (pending, addr, ts):
  - Event accepted when en_i=1, ch_valid_i[k]=1, and (hold k empty OR hold k granted this cycle). It is loaded at that edge.
  - Otherwise, with en_i=1, the event is dropped: drop_cnt +1 (saturates at all-ones) and overflow_o set. Multiple channels dropping in the same cycle add their total count.
  - en_i=0: events are ignored and not counted. Pending holds still drain.
- Arbitration:
  - Round-robin among pending holds, starting at (last granted + 1) mod NUM_CH. One grant per cycle.
  - The grant requires the buffer to be not full, or mode_wrap_i=1, or a pop happening this cycle.
  - The granted entry is written at the edge, and the RR pointer becomes the granted channel.
- Latency: strobe in cycle N -> hold at edge N -> earliest write at edge N+1 -> rd_valid_o=1 in cycle N+2.
- Buffer:
  - rd_valid_o = (count_o != 0). Head outputs are driven from storage at the read pointer. Pop on rd_valid_o & rd_ready_i.
  - Push and pop in the same cycle: count unchanged. This holds even when full, with no overwrite.
  - Full, mode_wrap_i=1, push without pop: the oldest entry is overwritten and the read pointer advances. Count stays DEPTH, overflow_o is set, drop_cnt is not incremented.
  - Full, mode_wrap_i=0, no pop: no grant. Holds stay pending, and further events on those channels are dropped.
  - Pointers wrap modulo DEPTH.
- clear_i: at the edge, empties the buffer and holds, clears overflow_o and drop_cnt_o, and resets the RR pointer. Events on ch_valid_i in the same cycle are discarded uncounted. The timestamp keeps running.
- rd_* outputs are don't-care when rd_valid_o=0.

Test Plan:
- Single event: reset, en=1, ch1 addr 0x0000_0040 at ts=5 -> rd_valid_o rises 2 cycles later; rd_ch=1, rd_addr=0x40, rd_time=5; pop -> count_o=0.
- Simultaneous events: ch0=0x100 and ch1=0x200 in the same cycle, RR pointer=1 -> ch0 written first, ch1 next cycle; both entries carry the same timestamp.
- Hold collision: ch0 strobes for 3 consecutive cycles while the buffer is full and mode_wrap=0, rd_ready=0 -> first event held, next 2 dropped; drop_cnt_o=2, overflow_o=1.
- Wrap mode: DEPTH=16, mode_wrap=1, 20 events on ch0 with addrs 0..19, no reads -> count_o=16, head addr=4, overflow_o=1, drop_cnt_o=0.
- Full push+pop: full buffer, rd_ready=1 with one pending event, mode_wrap=0 -> count_o stays 16, no overwrite, overflow_o unchanged.
- Clear/reset mid-run: 5 entries queued, assert clear_i with ch0 strobing -> next cycle count_o=0, drop_cnt_o=0, timestamp still increments. Repeat with rst_i -> timestamp=0.
